// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: instruction handshake, register file read/write ports and status flags between fetch, sequencer and register file
interface regfile_sequencer_if #(parameter int DATA_W = 8);
  logic instr_valid;
  logic [7:0] instr;
  logic instr_ready;
  logic [1:0] read_reg1;
  logic [1:0] read_reg2;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic write_enable;
  logic [1:0] write_reg;
  logic [DATA_W-1:0] write_data;
  logic done;
  logic zero_flag;
  logic carry_flag;
  modport master (
    input instr_valid, instr, read_data1, read_data2,
    output instr_ready, read_reg1, read_reg2, write_enable, write_reg, write_data, done, zero_flag, carry_flag
  );
  modport slave (
    output instr_valid, instr, read_data1, read_data2,
    input instr_ready, read_reg1, read_reg2, write_enable, write_reg, write_data, done, zero_flag, carry_flag
  );
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: 4-cycle IDLE/READ/EXEC/WRITE execute sequencer; ports clk, reset, bus (instr handshake, two read ports, write port, done, zero/carry flags)
module regfile_sequencer #(
  parameter int DATA_W = 8
) (
  input logic clk,
  input logic reset,
  regfile_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;
  state_t state, state_n;
  logic [7:0] instr_q;
  logic [DATA_W-1:0] op1, op2, result;
  logic [DATA_W:0] alu;
  logic zero_q, carry_q;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (bus.instr_valid ? READ : IDLE) : state_t'(state + 2'd1);
  end
  always_comb begin
    alu = instr_q[7:6] == 2'b00 ? {1'b0, op1} + {1'b0, op2} :
          instr_q[7:6] == 2'b01 ? {1'b0, op1} - {1'b0, op2} :
          instr_q[7:6] == 2'b10 ? {1'b0, op1 & op2} : {1'b0, op1};
  end
  always_ff @(posedge clk)
    if (reset) begin
      instr_q <= '0;
      op1 <= '0;
      op2 <= '0;
      result <= '0;
      zero_q <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      if (state == IDLE && bus.instr_valid) instr_q <= bus.instr;
      if (state == READ) begin
        op1 <= bus.read_data1;
        op2 <= bus.read_data2;
      end
      if (state == EXEC) begin
        result <= alu[DATA_W-1:0];
        zero_q <= alu[DATA_W-1:0] == '0;
        carry_q <= alu[DATA_W];
      end
    end
  assign bus.instr_ready = state == IDLE;
  assign bus.read_reg1 = instr_q[3:2];
  assign bus.read_reg2 = instr_q[1:0];
  assign bus.write_reg = instr_q[5:4];
  assign bus.write_data = result;
  assign bus.write_enable = state == WRITE;
  assign bus.done = state == WRITE;
  assign bus.zero_flag = zero_q;
  assign bus.carry_flag = carry_q;
endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle execute sequencer that drives the 4-entry, 8-bit register file through its two read ports and one write port.
- Accepts one 8-bit instruction per valid/ready handshake and reads both source registers.
- Computes the result, updates the zero/carry flags, and writes the result back to the destination register.
- Sits between instruction fetch and the register file.

Parameters:
- DATA_W, 8, datapath and register width; must match the register file word width.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous active-high reset
- instr_valid  input  1  instruction available on instr
- instr  input  8  instruction: [7:6] opcode, [5:4] rd, [3:2] rs1, [1:0] rs2
- instr_ready  output  1  sequencer can accept an instruction
- read_reg1  output  2  register file read port 1 address (rs1)
- read_reg2  output  2  register file read port 2 address (rs2)
- read_data1  input  DATA_W  register file read port 1 data (combinational)
- read_data2  input  DATA_W  register file read port 2 data (combinational)
- write_enable  output  1  register file write strobe
- write_reg  output  2  register file write address (rd)
- write_data  output  DATA_W  register file write data
- done  output  1  one-cycle pulse, instruction retired
- zero_flag  output  1  last result == 0
- carry_flag  output  1  carry/borrow of last ADD/SUB

Behaviour:
- Reset:
  - Synchronous, active-high: one clock and a synchronous active-high reset named reset.
  - Values: state=IDLE, latched instr=0x00, operand/result regs=0, zero_flag=0, carry_flag=0, done=0, write_enable=0.
  - instr_ready=1 in the first cycle after reset deasserts.
- Opcodes:
  - 00 ADD: rd <= rs1+rs2
  - 01 SUB: rd <= rs1-rs2
  - 10 AND: rd <= rs1&rs2
  - 11 MOV: rd <= rs1, rs2 ignored
- FSM states: IDLE -> READ -> EXEC -> WRITE -> IDLE; exactly 4 cycles per instruction.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready at a clock edge, latch instr and go to READ. Otherwise stay.
  - READ: read_reg1/read_reg2 driven from latched rs1/rs2. At the edge, capture read_data1/read_data2 into operand regs, go to EXEC.
  - EXEC: compute a DATA_W+1-bit result from the operand regs. At the edge, register result and flags, go to WRITE.
  - WRITE: write_enable=1, write_reg=rd, write_data=result, done=1 for exactly this cycle. Register file commits at the edge; return to IDLE.
- Outputs while not busy:
  - instr_ready=0 in READ/EXEC/WRITE.
  - read_reg1/read_reg2/write_reg hold the latched fields in all states; they are registered, never taken from the live instr bus.
  - write_enable=0 and done=0 outside WRITE.
- Flags:
  - Updated at the EXEC->WRITE edge only; they hold their value otherwise.
  - zero_flag = (result[DATA_W-1:0]==0) for all opcodes.
  - carry_flag:
    - ADD: carry out bit DATA_W.
    - SUB: borrow, 1 iff rs1<rs2 unsigned.
    - AND/MOV: cleared to 0.
- Arithmetic: unsigned modulo 2^DATA_W; no saturation.
- Boundary conditions:
  - instr_valid while busy: ignored and not latched; source must hold the instruction until accepted.
  - Back-to-back: the next accept can occur in the IDLE cycle right after WRITE, so the throughput is one instruction per 4 cycles.
  - Read-after-write: a dependent instruction's READ occurs ≥2 edges after the prior commit, so it always sees the new value. No forwarding is needed.
  - rd==rs1 or rd==rs2: legal; operands are captured in READ before the write.
  - Reset in any state takes priority over all transitions. The in-flight instruction is dropped with no write_enable and no done in the following cycle. Flags are cleared.
  - instr_valid together with reset: ignored.

Test Plan:
Bench models the 4-entry register file (combinational read, clocked write), preloaded R0=0x00, R1=0x05, R2=0x03, R3=0x00.
1. ADD: instr=0x36 (ADD R3,R1,R2), valid 1 cycle -> exactly 3 cycles after accept: write_enable=1, write_reg=3, write_data=0x08, done=1; zero=0, carry=0; instr_ready=1 on the next cycle.
2. ADD overflow and SUB: with R1=0xF0, R2=0x20, instr=0x36 -> write_data=0x10, carry=1. Then instr=0x4A (SUB R0,R2,R2) -> write_data=0x00, zero=1, carry=0. Then instr=0x46 (SUB R0,R1,R2) with R1=0x03, R2=0x05 -> write_data=0xFE, carry=1.
3. Back-to-back dependency: instr_valid held high with 0x36 then 0xCC (MOV R0,R3) -> accepts exactly 4 cycles apart; the second write has write_reg=0, write_data=0x08.
4. Busy stall: present 0x96 during EXEC of a prior instruction -> not accepted and no extra write. It is accepted only in the next IDLE; 0x96 gives AND R1,R1,R2 = 0x05&0x03 = 0x01.
5. Mid-operation reset: assert reset for 1 cycle during EXEC of 0x36 -> no write_enable and no done afterwards; R3 unchanged; flags=0; instr_ready=1 the cycle after reset deasserts.
6. Post-reset state: hold reset 3 cycles with instr_valid=1 -> write_enable=0, done=0 throughout. The first instruction is accepted only on the first non-reset cycle.
